// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the 640x480@60 raster path.
//   - Default active/porch/sync widths for both axes.
//   - Derived totals and sync window bounds for the defaults.
//   - Counter type and the per-pixel flag bundle (HS, VS, visible) that
//     travels alongside each pixel request.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Default 640x480@60 timing (pixel clock ~25.175 MHz).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Derived values for the defaults.
  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  // Per-pixel control flags; sync levels are stored as the pin levels
  // (active-low) so the delay line output can drive the DAC directly.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic vis;
  } scan_flags_t;

  localparam scan_flags_t FLAGS_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

endpackage

// File: rtl/vga_align_delay.sv
// ---------------------------------------------------------------------------
// vga_align_delay
// Fixed-depth shift register with asynchronous active-high reset to a
// per-bit value. Used to hold the HS/VS/visible flags back until the
// pipeline's pixel data for the same request arrives.
// Ports:
//   clk        in   clock
//   rst        in   async active-high reset (all stages -> RST_VAL)
//   din        in   WIDTH  value entering stage 0
//   dout       out  WIDTH  value after DEPTH cycles
//   dout_early out  WIDTH  value that dout will take on the next edge
// ---------------------------------------------------------------------------
module vga_align_delay #(
  parameter int                WIDTH   = 3,
  parameter int                DEPTH   = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_early
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    // NOTE: every combinational output gets a value on every path (here via
    // the full loop plus stage 0) so no latch is inferred.
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: this is a small flop chain, not a RAM, so every stage is reset;
  // that is what flushes in-flight pixels when reset hits mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout       = stage_q[DEPTH-1];
  assign dout_early = stage_d[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl
// Raster scan initiator: runs the H/V counters, issues one pixel read
// request per visible pixel with its X/Y, and re-aligns HS/VS/BLANK_N with
// the RGB the pixel pipeline returns RD_LATENCY cycles later.
// Ports:
//   CLK            in   pixel clock
//   RST            in   async active-high reset
//   iRed/iGreen/iBlue in 10 each  pipeline return data
//   oRequest       out  pixel read strobe
//   oVGA_X/oVGA_Y  out  11 each   requested coordinate (0 when blanked)
//   oFrameStart    out  pulse with the request for (0,0)
//   oVGA_R/G/B     out  10 each   DAC colour (0 when blanked)
//   oVGA_HS/VS     out  active-low syncs
//   oVGA_BLANK_N   out  high on visible pixels
// RD_LATENCY must lie in 1..4.
// ---------------------------------------------------------------------------
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int RD_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  iRed,
  input  logic [9:0]  iGreen,
  input  logic [9:0]  iBlue,
  output logic        oRequest,
  output logic [10:0] oVGA_X,
  output logic [10:0] oVGA_Y,
  output logic        oFrameStart,
  output logic [9:0]  oVGA_R,
  output logic [9:0]  oVGA_G,
  output logic [9:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT     = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT     = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END    = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END    = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  // Scan counters.
  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // Request register.
  logic        req_q, req_d;
  cnt_t        x_q, x_d;
  cnt_t        y_q, y_d;
  logic        fs_q, fs_d;
  scan_flags_t flags_q, flags_d;

  // Delay line outputs.
  scan_flags_t flags_out;
  scan_flags_t flags_early;

  // RGB output register.
  logic [29:0] rgb_q, rgb_d;

  logic visible;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? cnt_t'(0) : v_cnt_q + 1'b1;
    end
  end

  assign visible = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

  always_comb begin
    req_d         = visible;
    x_d           = visible ? h_cnt_q : cnt_t'(0);
    y_d           = visible ? v_cnt_q : cnt_t'(0);
    fs_d          = (h_cnt_q == '0) && (v_cnt_q == '0);
    flags_d.hs_n  = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    flags_d.vs_n  = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    flags_d.vis   = visible;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      flags_q <= FLAGS_IDLE;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      req_q   <= req_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      flags_q <= flags_d;
    end
  end

  // The flags leave the delay line on the same edge that the RGB register
  // captures the pipeline data; the RGB gate therefore looks at the value
  // about to enter the last stage rather than the last stage itself.
  vga_align_delay #(
    .WIDTH   ($bits(scan_flags_t)),
    .DEPTH   (RD_LATENCY),
    .RST_VAL (FLAGS_IDLE)
  ) u_align (
    .clk        (CLK),
    .rst        (RST),
    .din        (flags_q),
    .dout       (flags_out),
    .dout_early (flags_early)
  );

  always_comb begin
    rgb_d = flags_early.vis ? {iRed, iGreen, iBlue} : 30'd0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign oRequest     = req_q;
  assign oVGA_X       = x_q;
  assign oVGA_Y       = y_q;
  assign oFrameStart  = fs_q;
  assign oVGA_R       = rgb_q[29:20];
  assign oVGA_G       = rgb_q[19:10];
  assign oVGA_B       = rgb_q[9:0];
  assign oVGA_HS      = flags_out.hs_n;
  assign oVGA_VS      = flags_out.vs_n;
  assign oVGA_BLANK_N = flags_out.vis;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_ctrl
// Three instances share clock and reset:
//   a: default 640x480 timing, RD_LATENCY=2 (line scan, HS placement)
//   b: reduced timing (24x17), RD_LATENCY=1 (frame wrap, data alignment)
//   c: reduced timing (24x17), RD_LATENCY=4 (VS placement, data alignment)
// Each instance has a pipeline model returning {Y,X,X^Y} RD_LATENCY cycles
// after its request and random data otherwise. Expected outputs come from
// the cycle number since reset release, using plain division/modulo over the
// frame geometry.
// ---------------------------------------------------------------------------
module tb_vga_scan_ctrl;

  typedef struct packed {
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic [29:0] rgb;
    logic        hs;
    logic        vs;
    logic        bn;
  } obs_t;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb, lat;
  } tim_t;

  tim_t tim_a = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  tim_t tim_b = '{16, 2, 3, 3, 10, 2, 2, 3, 1};
  tim_t tim_c = '{16, 2, 3, 3, 10, 2, 2, 3, 4};

  localparam int SMALL_FRAME = 24 * 17;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  // Instance a.
  logic [29:0] a_rgb_in = '1;
  logic        a_req, a_fs, a_hs, a_vs, a_bn;
  logic [10:0] a_x, a_y;
  logic [9:0]  a_r, a_g, a_b;
  obs_t        obs_a;
  logic [3:0][30:0] a_hist = '0;

  // Instance b.
  logic [29:0] b_rgb_in = '1;
  logic        b_req, b_fs, b_hs, b_vs, b_bn;
  logic [10:0] b_x, b_y;
  logic [9:0]  b_r, b_g, b_b;
  obs_t        obs_b;
  logic [3:0][30:0] b_hist = '0;

  // Instance c.
  logic [29:0] c_rgb_in = '1;
  logic        c_req, c_fs, c_hs, c_vs, c_bn;
  logic [10:0] c_x, c_y;
  logic [9:0]  c_r, c_g, c_b;
  obs_t        obs_c;
  logic [3:0][30:0] c_hist = '0;

  assign obs_a = {a_req, a_x, a_y, a_fs, a_r, a_g, a_b, a_hs, a_vs, a_bn};
  assign obs_b = {b_req, b_x, b_y, b_fs, b_r, b_g, b_b, b_hs, b_vs, b_bn};
  assign obs_c = {c_req, c_x, c_y, c_fs, c_r, c_g, c_b, c_hs, c_vs, c_bn};

  vga_scan_ctrl #(.RD_LATENCY(2)) dut_a (
    .CLK(CLK), .RST(RST),
    .iRed(a_rgb_in[29:20]), .iGreen(a_rgb_in[19:10]), .iBlue(a_rgb_in[9:0]),
    .oRequest(a_req), .oVGA_X(a_x), .oVGA_Y(a_y), .oFrameStart(a_fs),
    .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b),
    .oVGA_HS(a_hs), .oVGA_VS(a_vs), .oVGA_BLANK_N(a_bn)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .RD_LATENCY(1)
  ) dut_b (
    .CLK(CLK), .RST(RST),
    .iRed(b_rgb_in[29:20]), .iGreen(b_rgb_in[19:10]), .iBlue(b_rgb_in[9:0]),
    .oRequest(b_req), .oVGA_X(b_x), .oVGA_Y(b_y), .oFrameStart(b_fs),
    .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
    .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_BLANK_N(b_bn)
  );

  vga_scan_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .RD_LATENCY(4)
  ) dut_c (
    .CLK(CLK), .RST(RST),
    .iRed(c_rgb_in[29:20]), .iGreen(c_rgb_in[19:10]), .iBlue(c_rgb_in[9:0]),
    .oRequest(c_req), .oVGA_X(c_x), .oVGA_Y(c_y), .oFrameStart(c_fs),
    .oVGA_R(c_r), .oVGA_G(c_g), .oVGA_B(c_b),
    .oVGA_HS(c_hs), .oVGA_VS(c_vs), .oVGA_BLANK_N(c_bn)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int t        = -1;   // edges since reset release; -1 while in reset

  // Directed measurements.
  int a_req_cnt  = 0;
  int a_hs_cnt   = 0;
  int a_hs_first = -1;
  int b_fs_cnt   = 0;
  int b_last_fs  = -1;
  int c_vs_cnt   = 0;
  int c_vs_first = -1;

  task automatic check(input string tag, input int tc, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, tc, obs, exp);
    end
  endtask

  // Expected outputs after edge tc, from frame geometry alone.
  function automatic obs_t model(input tim_t p, input int tc);
    obs_t e;
    int ht, vt, ft, pos, h, v, xv;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (tc < 0) return e;
    ht  = p.ha + p.hf + p.hsw + p.hb;
    vt  = p.va + p.vf + p.vsw + p.vb;
    ft  = ht * vt;
    pos = tc % ft;
    h   = pos % ht;
    v   = pos / ht;
    e.req = (h < p.ha) && (v < p.va);
    if (e.req) begin
      e.x = 11'(h);
      e.y = 11'(v);
    end
    e.fs = (pos == 0);
    if (tc >= p.lat) begin
      pos  = (tc - p.lat) % ft;
      h    = pos % ht;
      v    = pos / ht;
      e.hs = !((h >= p.ha + p.hf) && (h < p.ha + p.hf + p.hsw));
      e.vs = !((v >= p.va + p.vf) && (v < p.va + p.vf + p.vsw));
      e.bn = (h < p.ha) && (v < p.va);
      if (e.bn) begin
        xv    = h ^ v;
        e.rgb = {v[9:0], h[9:0], xv[9:0]};
      end
    end
    return e;
  endfunction

  task automatic check_dut(input string name, input obs_t o, input obs_t e, input int tc);
    check({name, ".req"},  tc, 32'(o.req), 32'(e.req));
    check({name, ".xy"},   tc, 32'({o.x, o.y}), 32'({e.x, e.y}));
    check({name, ".fs"},   tc, 32'(o.fs), 32'(e.fs));
    check({name, ".rgb"},  tc, 32'(o.rgb), 32'(e.rgb));
    check({name, ".sync"}, tc, 32'({o.hs, o.vs, o.bn}), 32'({e.hs, e.vs, e.bn}));
  endtask

  // Pipeline model: remembers the last four requests and returns the data
  // for the one issued lat-1 negedges ago, or random data when none.
  task automatic pipe_step(input obs_t o, input int lat,
                           inout logic [3:0][30:0] hist, output logic [29:0] rgb_in);
    logic [9:0] xv;
    xv   = o.x[9:0] ^ o.y[9:0];
    hist = {hist[2:0], {o.req, o.y[9:0], o.x[9:0], xv}};
    if (RST) rgb_in = '1;
    else if (hist[lat-1][30]) rgb_in = hist[lat-1][29:0];
    else rgb_in = 30'($urandom);
  endtask

  task automatic step();
    @(posedge CLK);
    if (!RST) t++;
    @(negedge CLK);
    pipe_step(obs_a, tim_a.lat, a_hist, a_rgb_in);
    pipe_step(obs_b, tim_b.lat, b_hist, b_rgb_in);
    pipe_step(obs_c, tim_c.lat, c_hist, c_rgb_in);
    check_dut("a", obs_a, model(tim_a, t), t);
    check_dut("b", obs_b, model(tim_b, t), t);
    check_dut("c", obs_c, model(tim_c, t), t);
    if (t >= 0 && t < 800) begin
      if (obs_a.req) a_req_cnt++;
      if (!obs_a.hs) begin
        if (a_hs_first < 0) a_hs_first = t;
        a_hs_cnt++;
      end
    end
    if (t >= 0 && obs_b.fs) begin
      if (b_last_fs >= 0) check("b.fs_period", t, 32'(t - b_last_fs), 32'(SMALL_FRAME));
      b_fs_cnt++;
      b_last_fs = t;
    end
    if (t >= 0 && t < SMALL_FRAME && !obs_c.vs) begin
      if (c_vs_first < 0) c_vs_first = t;
      c_vs_cnt++;
    end
  endtask

  initial begin
    // Reset held for 5 cycles with all-ones pipeline data.
    RST = 1'b1;
    t   = -1;
    repeat (5) step();
    RST = 1'b0;

    // First line of the default-timing instance.
    repeat (800) step();
    check("a.line_requests", t, 32'(a_req_cnt), 32'd640);
    check("a.hs_start",      t, 32'(a_hs_first), 32'd658);
    check("a.hs_width",      t, 32'(a_hs_cnt), 32'd96);

    // Further lines plus several reduced frames, random length.
    repeat (1600 + $urandom_range(0, SMALL_FRAME - 1)) step();
    check("c.vs_start", t, 32'(c_vs_first), 32'((12 * 24) + 4));
    check("c.vs_width", t, 32'(c_vs_cnt), 32'(2 * 24));
    check("b.fs_count", t, 32'(b_fs_cnt), 32'((t / SMALL_FRAME) + 1));

    // Mid-frame reset between edges: outputs must clear immediately.
    RST = 1'b1;
    #1;
    t = -1;
    check_dut("a.async", obs_a, model(tim_a, -1), t);
    check_dut("b.async", obs_b, model(tim_b, -1), t);
    check_dut("c.async", obs_c, model(tim_c, -1), t);
    b_last_fs = -1;
    b_fs_cnt  = 0;
    a_req_cnt = 0;
    repeat (3) step();
    RST = 1'b0;

    // Restart from (0,0).
    repeat (900) step();
    check("a.restart_requests", t, 32'(a_req_cnt), 32'd640);
    check("b.restart_fs_count", t, 32'(b_fs_cnt), 32'((t / SMALL_FRAME) + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
